// File: rtl/bit_serializer_if.sv
// Handshake and serial-output bundle for bit_serializer.
// master: upstream word producer / serial consumer side; slave: the serializer.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             serial_out;
    logic             serial_valid;
    logic             word_done;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  serial_out,
        input  serial_valid,
        input  word_done
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output serial_out,
        output serial_valid,
        output word_done
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: accepts a WIDTH-bit word on a valid/ready
// handshake and emits it one bit per cycle, MSB or LSB first, followed by
// GAP idle cycles. Serial outputs are registered; data_ready is decoded from
// state and counters only.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic            clk,
    input  logic            rst,
    bit_serializer_if.slave bus
);
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);
    localparam logic [3:0]    LAST_GAP = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_bit_cnt;
    logic [3:0]       r_gap_cnt;
    logic             r_serial_out;
    logic             r_serial_valid;
    logic             r_word_done;

    logic             w_ready;
    logic             w_xfer;
    logic             w_last_bit;
    logic             w_first_bit;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_shift_next;

    assign w_last_bit = (r_bit_cnt == LAST_BIT);
    assign w_xfer     = bus.data_valid && w_ready;

    // The first bit is taken straight from data_in so it appears the cycle
    // after the transfer; the register then holds the word and is shifted so
    // that the upcoming bit always sits next to the end being emitted.
    assign w_first_bit  = MSB_FIRST ? bus.data_in[WIDTH-1] : bus.data_in[0];
    assign w_next_bit   = MSB_FIRST ? r_shift[WIDTH-2] : r_shift[1];
    assign w_shift_next = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                    : {1'b0, r_shift[WIDTH-1:1]};

    // Ready decode from state and counters; forced low while reset is held.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_IDLE:  w_ready = 1'b1;
            S_SHIFT: w_ready = (GAP == 0) && w_last_bit;
            S_GAP:   w_ready = (r_gap_cnt == LAST_GAP);
            default: w_ready = 1'b0;
        endcase
        if (rst) begin
            w_ready = 1'b0;
        end
    end

    // Serializer FSM with registered serial outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_gap_cnt      <= '0;
            r_serial_out   <= 1'b0;
            r_serial_valid <= 1'b0;
            r_word_done    <= 1'b0;
        end else if (w_xfer) begin
            // Transfers only happen in IDLE, the last SHIFT bit (GAP=0) or
            // the final GAP cycle, so one load path serves all three.
            r_state        <= S_SHIFT;
            r_shift        <= bus.data_in;
            r_bit_cnt      <= '0;
            r_gap_cnt      <= '0;
            r_serial_out   <= w_first_bit;
            r_serial_valid <= 1'b1;
            r_word_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_serial_out   <= 1'b0;
                    r_serial_valid <= 1'b0;
                    r_word_done    <= 1'b0;
                end
                S_SHIFT: begin
                    if (!w_last_bit) begin
                        r_bit_cnt      <= r_bit_cnt + 1'b1;
                        r_shift        <= w_shift_next;
                        r_serial_out   <= w_next_bit;
                        r_serial_valid <= 1'b1;
                        r_word_done    <= (r_bit_cnt == PRE_LAST);
                    end else begin
                        r_bit_cnt      <= '0;
                        r_gap_cnt      <= '0;
                        r_serial_out   <= 1'b0;
                        r_serial_valid <= 1'b0;
                        r_word_done    <= 1'b0;
                        r_state        <= (GAP > 0) ? S_GAP : S_IDLE;
                    end
                end
                S_GAP: begin
                    r_serial_out   <= 1'b0;
                    r_serial_valid <= 1'b0;
                    r_word_done    <= 1'b0;
                    if (r_gap_cnt == LAST_GAP) begin
                        r_gap_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_bit_cnt      <= '0;
                    r_gap_cnt      <= '0;
                    r_serial_out   <= 1'b0;
                    r_serial_valid <= 1'b0;
                    r_word_done    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_ready   = w_ready;
    assign bus.serial_out   = r_serial_out;
    assign bus.serial_valid = r_serial_valid;
    assign bus.word_done    = r_word_done;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: four instances with different bit order / gap
// settings, checked every cycle against a timeline model of the handshake.
module tb_bit_serializer;
    localparam int NDUT            = 4;
    localparam bit MSBS [NDUT]     = '{1'b1, 1'b0, 1'b1, 1'b0};
    localparam int GAPS [NDUT]     = '{0, 0, 2, 15};

    logic            clk;
    logic            rst;
    logic [7:0]      din [NDUT];
    logic [NDUT-1:0] dv;
    logic [NDUT-1:0] so;
    logic [NDUT-1:0] sv;
    logic [NDUT-1:0] wd;
    logic [NDUT-1:0] dr;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        bit_serializer_if #(.WIDTH(8)) bus ();
        assign bus.data_in    = din[g];
        assign bus.data_valid = dv[g];
        assign so[g]          = bus.serial_out;
        assign sv[g]          = bus.serial_valid;
        assign wd[g]          = bus.word_done;
        assign dr[g]          = bus.data_ready;

        bit_serializer #(
            .WIDTH    (8),
            .MSB_FIRST(MSBS[g]),
            .GAP      (GAPS[g])
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_pass;

    // Model: a word accepted in cycle a occupies bit cycles a+1..a+8 and the
    // block is ready again from cycle a+8+GAP onwards.
    int unsigned cyc;
    logic        in_reset;
    logic        rnd;
    logic        m_has  [NDUT];
    int unsigned m_acc  [NDUT];
    logic [7:0]  m_word [NDUT];
    int unsigned m_rdy  [NDUT];
    logic [7:0]  q [NDUT][$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic compare();
        for (int g = 0; g < NDUT; g++) begin
            logic        ev, eo, ed, er;
            logic [7:0]  w;
            int unsigned i;
            er = !in_reset && (cyc >= m_rdy[g]);
            ev = 1'b0;
            eo = 1'b0;
            ed = 1'b0;
            w  = m_word[g];
            if (!in_reset && m_has[g] && cyc > m_acc[g] && cyc <= m_acc[g] + 8) begin
                i  = cyc - m_acc[g] - 1;
                ev = 1'b1;
                eo = MSBS[g] ? w[7 - i] : w[i];
                ed = (i == 7);
            end
            check($sformatf("d%0d_c%0d_valid", g, cyc), 32'(sv[g]), 32'(ev));
            check($sformatf("d%0d_c%0d_bit",   g, cyc), 32'(so[g]), 32'(eo));
            check($sformatf("d%0d_c%0d_done",  g, cyc), 32'(wd[g]), 32'(ed));
            check($sformatf("d%0d_c%0d_ready", g, cyc), 32'(dr[g]), 32'(er));
        end
    endtask

    task automatic drive();
        for (int g = 0; g < NDUT; g++) begin
            logic rdy;
            din[g] = 8'($urandom);
            if (in_reset) begin
                dv[g] = 1'($urandom_range(0, 1));
                continue;
            end
            rdy = (cyc >= m_rdy[g]);
            if (q[g].size() > 0) begin
                dv[g] = 1'b1;
                if (rdy) din[g] = q[g][0];
            end else if (rnd) begin
                dv[g] = ($urandom_range(0, 3) != 0);
            end else begin
                dv[g] = 1'b0;
            end
            if (rdy && dv[g]) begin
                m_has[g]  = 1'b1;
                m_acc[g]  = cyc;
                m_word[g] = din[g];
                m_rdy[g]  = cyc + 8 + GAPS[g];
                if (q[g].size() > 0) void'(q[g].pop_front());
            end
        end
    endtask

    task automatic step(input bit a_rst, input bit a_rel);
        @(posedge clk);
        cyc++;
        if (a_rst) begin
            #2;
            rst      = 1'b1;
            in_reset = 1'b1;
            for (int g = 0; g < NDUT; g++) m_has[g] = 1'b0;
            #1;
            for (int g = 0; g < NDUT; g++) begin
                check($sformatf("d%0d_async_valid", g), 32'(sv[g]), 32'd0);
                check($sformatf("d%0d_async_bit",   g), 32'(so[g]), 32'd0);
                check($sformatf("d%0d_async_done",  g), 32'(wd[g]), 32'd0);
                check($sformatf("d%0d_async_ready", g), 32'(dr[g]), 32'd0);
            end
        end else if (a_rel) begin
            #2;
            rst      = 1'b0;
            in_reset = 1'b0;
            for (int g = 0; g < NDUT; g++) begin
                m_has[g] = 1'b0;
                m_rdy[g] = cyc;
            end
        end
        @(negedge clk);
        compare();
        drive();
    endtask

    initial begin
        rst      = 1'b1;
        in_reset = 1'b1;
        rnd      = 1'b0;
        cyc      = 0;
        n_checks = 0;
        n_pass   = 0;
        for (int g = 0; g < NDUT; g++) begin
            dv[g]     = 1'b0;
            din[g]    = '0;
            m_has[g]  = 1'b0;
            m_acc[g]  = 0;
            m_word[g] = '0;
            m_rdy[g]  = 0;
        end

        repeat (3) step(0, 0);
        step(0, 1);

        q[0].push_back(8'hD0);
        q[1].push_back(8'h0B);
        q[2].push_back(8'hFF);
        q[2].push_back(8'h00);
        q[3].push_back(8'h5A);
        repeat (30) step(0, 0);

        q[0].push_back(8'hA5);
        q[0].push_back(8'h3C);
        repeat (30) step(0, 0);

        q[0].push_back(8'hD0);
        repeat (4) step(0, 0);
        step(1, 0);
        repeat (2) step(0, 0);
        step(0, 1);
        q[0].push_back(8'h81);
        repeat (20) step(0, 0);

        rnd = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if (in_reset) step(0, 1);
            else          step($urandom_range(0, 199) == 0, 0);
        end
        if (in_reset) step(0, 1);
        rnd = 1'b0;
        repeat (30) step(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
